rgb_led_arbiter: RTL
====================

RGB_LED_ARBITER -- requirements
Module: rgb_led_arbiter

Interface
REQ-001 The block SHALL declare these parameters: PRESCALE, default 24, int_osc cycles per PWM step (range 1..65535); SLICE_PERIODS, default 16, PWM periods per grant (range 1..255).
REQ-002 The block SHALL declare these ports:
  - clk  in  1  int_osc domain clock.
  - rst_n  in  1  asynchronous active-low reset.
  - req  in  2  per-requester level request.
  - color0  in  24  requester 0 colour {red[23:16], green[15:8], blue[7:0]}.
  - color1  in  24  requester 1 colour, same packing as color0.
  - gnt  out  2  one-hot grant, 2'b00 when idle.
  - rgb0_pwm  out  1  green PWM to SB_RGBA_DRV RGB0PWM.
  - rgb1_pwm  out  1  blue PWM to SB_RGBA_DRV RGB1PWM.
  - rgb2_pwm  out  1  red PWM to SB_RGBA_DRV RGB2PWM.
  - led_en  out  1  drives RGBLEDEN and CURREN.
REQ-003 One clock and one reset only: clk plus asynchronous active-low rst_n. This is already decided.

Function
REQ-004 Prescaler SHALL count 0..PRESCALE-1 and wrap; tick is asserted in the cycle the count equals PRESCALE-1.
REQ-005 The 8-bit pwm_cnt SHALL increment on each tick and wrap from 255 to 0; period_end = tick && pwm_cnt==255.
REQ-006 Duty registers (r,g,b) SHALL load only on period_end, from the colour of the requester granted in the next period; 0 is loaded when idle.
REQ-007 Each PWM output SHALL be registered as (pwm_cnt < duty): duty 0 gives constant low, duty 255 gives high for 255 of 256 steps.
REQ-008 The FSM SHALL have three states: IDLE, SERVE0 and SERVE1; gnt SHALL be 2'b01 in SERVE0, 2'b10 in SERVE1 and 2'b00 in IDLE.
REQ-009 Arbitration SHALL be evaluated only on period_end; a state change SHALL take effect in the following cycle.
REQ-010 From IDLE, any asserted request SHALL be served; if both are asserted, the requester not equal to last_served SHALL win.
REQ-011 In SERVEn, a slice counter SHALL count period_ends; at SLICE_PERIODS, the other requester SHALL be granted if it requests, otherwise n is kept if still requesting, otherwise the FSM SHALL go to IDLE.
REQ-012 If req[n] drops while in SERVEn, the switch SHALL happen at the next period_end (no mid-period cut), to the other requester or to IDLE.
REQ-013 The slice counter SHALL clear on every grant change, including a re-grant to the same requester.
REQ-014 last_served SHALL update whenever the FSM enters SERVE0 or SERVE1.
REQ-015 Colour input changes mid-period SHALL NOT affect the current period.
REQ-016 led_en SHALL be 1 whenever rst_n is high.

Reset
REQ-017 rst_n low SHALL asynchronously clear: prescaler, pwm_cnt, duties, slice counter, all PWM outputs, gnt, and led_en (all to 0); the FSM goes to IDLE and last_served to 1.
REQ-018 Reset mid-slice SHALL drop the grant immediately; after release, the first arbitration occurs at the first period_end.

Configuration
REQ-019 With RGB_ARB_BREATHE_EN defined, IDLE SHALL drive a breathing green: the green duty ramps 0->255->0 in steps of 1 per period_end, while red and blue stay 0; the ramp resets to 0 on leaving IDLE.
REQ-020 Without RGB_ARB_BREATHE_EN, IDLE duties SHALL all be 0 and no ramp logic SHALL exist.

Structure
REQ-021 A shared package rgb_pkg SHALL hold the FSM state enum, the colour-field bit positions and the channel-to-RGBn mapping constants (RGB0 green, RGB1 blue, RGB2 red).
REQ-022 One sub-module, rgb_pwm_gen, SHALL hold the prescaler, pwm_cnt and the three comparators; the arbiter FSM lives in the top.
REQ-023 The top SHALL NOT instantiate SB_HFOSC or SB_RGBA_DRV; the parent wires them.

Verification
REQ-024 Test: PRESCALE=1, req=01, color0=0x00FF00 -> gnt=01 after the first period_end; rgb0_pwm high 255 of every 256 cycles; rgb1_pwm and rgb2_pwm always 0.
REQ-025 Test: req=11 held, SLICE_PERIODS=2 -> gnt sequence 01,10,01,... with each grant lasting exactly 2 periods (512 cycles at PRESCALE=1).
REQ-026 Test: in SERVE0, drop req[0] at pwm_cnt=100 -> gnt stays 01 until period_end, then becomes 00 (or 10 if req[1] is asserted).
REQ-027 Test: color0 changes 0x800000->0x100000 mid-period -> rgb2_pwm high exactly 128 steps in that period and 16 steps in the next.
REQ-028 Test: assert rst_n low mid-slice -> all outputs 0 in the same cycle; after release with req=10, gnt=10 at the first period_end.
REQ-029 Test: BREATHE_EN defined, req=00 -> the green duty sampled per period is 0,1,2,...,255,254,...,0; red and blue PWM stay 0.

Source files
------------

// File: rtl/rgb_pkg.sv
// Shared definitions for the RGB LED arbiter: FSM states, colour field layout
// and the colour-channel to SB_RGBA_DRV RGBn pin mapping.
package rgb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE0 = 2'd1,
        SERVE1 = 2'd2
    } arb_state_e;

    localparam int RED_LSB = 16;
    localparam int GRN_LSB = 8;
    localparam int BLU_LSB = 0;

    localparam int CH_RED = 0;
    localparam int CH_GRN = 1;
    localparam int CH_BLU = 2;

    // The LED driver pins are not in R,G,B order on the package.
    localparam int RGB0_CH = CH_GRN;
    localparam int RGB1_CH = CH_BLU;
    localparam int RGB2_CH = CH_RED;

    typedef logic [2:0][7:0] duty_t;

    function automatic duty_t unpack_color(input logic [23:0] color);
        duty_t d;
        d[CH_RED] = color[RED_LSB +: 8];
        d[CH_GRN] = color[GRN_LSB +: 8];
        d[CH_BLU] = color[BLU_LSB +: 8];
        return d;
    endfunction

endpackage

// File: rtl/rgb_pwm_gen.sv
// PWM timebase for the RGB LED: prescaler, 8-bit step counter and one
// registered comparator per colour channel.
module rgb_pwm_gen
    import rgb_pkg::*;
#(
    parameter int PRESCALE = 24
) (
    input  logic  clk,
    input  logic  rst_n,
    input  duty_t duty,
    output logic  period_end,
    output logic  rgb0_pwm,
    output logic  rgb1_pwm,
    output logic  rgb2_pwm
);

    logic [15:0] presc_q, presc_d;
    logic [7:0]  pwm_cnt_q, pwm_cnt_d;
    logic [2:0]  pwm_q, pwm_d;
    logic        tick;

    always_comb begin
        tick       = (presc_q == 16'(PRESCALE - 1));
        period_end = tick && (pwm_cnt_q == 8'd255);
        presc_d    = tick ? 16'd0 : presc_q + 16'd1;
        pwm_cnt_d  = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
        for (int ch = 0; ch < 3; ch++) begin
            pwm_d[ch] = (pwm_cnt_q < duty[ch]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            pwm_cnt_q <= '0;
            pwm_q     <= '0;
        end else begin
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_d;
            pwm_q     <= pwm_d;
        end
    end

    assign rgb0_pwm = pwm_q[RGB0_CH];
    assign rgb1_pwm = pwm_q[RGB1_CH];
    assign rgb2_pwm = pwm_q[RGB2_CH];

endmodule

// File: rtl/rgb_led_arbiter.sv
// Time-slices one RGB LED between two requesters, switching only on PWM
// period boundaries. Define RGB_ARB_BREATHE_EN for a breathing green when idle.
module rgb_led_arbiter
    import rgb_pkg::*;
#(
    parameter int PRESCALE      = 24,
    parameter int SLICE_PERIODS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [23:0] color0,
    input  logic [23:0] color1,
    output logic [1:0]  gnt,
    output logic        rgb0_pwm,
    output logic        rgb1_pwm,
    output logic        rgb2_pwm,
    output logic        led_en
);

    arb_state_e  state_q, state_d, nxt;
    logic        last_q, last_d;
    logic [7:0]  slice_q, slice_d;
    logic [8:0]  slice_inc;
    logic [1:0]  gnt_q, gnt_d;
    duty_t       duty_q, duty_d;
    logic        regrant;
    logic        period_end;

`ifdef RGB_ARB_BREATHE_EN
    logic [7:0]  ramp_q, ramp_d;
    logic        ramp_up_q, ramp_up_d;

    // Returns {direction, level}; the ramp bounces off 0 and 255.
    function automatic logic [8:0] breathe_step(input logic up, input logic [7:0] lvl);
        if (up) return (lvl == 8'd255) ? {1'b0, 8'd254} : {1'b1, lvl + 8'd1};
        else    return (lvl == 8'd0)   ? {1'b1, 8'd1}   : {1'b0, lvl - 8'd1};
    endfunction
`endif

    always_comb begin
        slice_inc = {1'b0, slice_q} + 9'd1;
        nxt       = state_q;
        regrant   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req == 2'b11)  nxt = last_q ? SERVE0 : SERVE1;
                else if (req[0])   nxt = SERVE0;
                else if (req[1])   nxt = SERVE1;
            end
            SERVE0: begin
                if (!req[0]) begin
                    nxt = req[1] ? SERVE1 : IDLE;
                end else if (slice_inc >= 9'(SLICE_PERIODS)) begin
                    nxt     = req[1] ? SERVE1 : SERVE0;
                    regrant = !req[1];
                end
            end
            SERVE1: begin
                if (!req[1]) begin
                    nxt = req[0] ? SERVE0 : IDLE;
                end else if (slice_inc >= 9'(SLICE_PERIODS)) begin
                    nxt     = req[0] ? SERVE0 : SERVE1;
                    regrant = !req[0];
                end
            end
            default: nxt = IDLE;
        endcase

        state_d = state_q;
        last_d  = last_q;
        slice_d = slice_q;
        gnt_d   = gnt_q;
        duty_d  = duty_q;
`ifdef RGB_ARB_BREATHE_EN
        ramp_d    = ramp_q;
        ramp_up_d = ramp_up_q;
`endif
        // Grant and duties move together so a period never mixes two owners.
        if (period_end) begin
            state_d = nxt;
            slice_d = (nxt == state_q && !regrant && nxt != IDLE) ? slice_inc[7:0] : 8'd0;
            case (nxt)
                SERVE0: begin
                    gnt_d  = 2'b01;
                    last_d = 1'b0;
                    duty_d = unpack_color(color0);
                end
                SERVE1: begin
                    gnt_d  = 2'b10;
                    last_d = 1'b1;
                    duty_d = unpack_color(color1);
                end
                default: begin
                    gnt_d  = 2'b00;
                    duty_d = '0;
`ifdef RGB_ARB_BREATHE_EN
                    if (state_q == IDLE) begin
                        {ramp_up_d, ramp_d} = breathe_step(ramp_up_q, ramp_q);
                        duty_d[CH_GRN]      = ramp_d;
                    end
`endif
                end
            endcase
`ifdef RGB_ARB_BREATHE_EN
            if (nxt != IDLE || state_q != IDLE) begin
                ramp_d    = 8'd0;
                ramp_up_d = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            slice_q   <= '0;
            gnt_q     <= '0;
            duty_q    <= '0;
`ifdef RGB_ARB_BREATHE_EN
            ramp_q    <= '0;
            ramp_up_q <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            slice_q   <= slice_d;
            gnt_q     <= gnt_d;
            duty_q    <= duty_d;
`ifdef RGB_ARB_BREATHE_EN
            ramp_q    <= ramp_d;
            ramp_up_q <= ramp_up_d;
`endif
        end
    end

    rgb_pwm_gen #(
        .PRESCALE (PRESCALE)
    ) u_pwm (
        .clk        (clk),
        .rst_n      (rst_n),
        .duty       (duty_q),
        .period_end (period_end),
        .rgb0_pwm   (rgb0_pwm),
        .rgb1_pwm   (rgb1_pwm),
        .rgb2_pwm   (rgb2_pwm)
    );

    assign gnt    = gnt_q;
    assign led_en = rst_n;

endmodule
